// File: rtl/wb_copy_master.sv
// Wishbone classic initiator that copies a block of 32-bit words, one single read then one
// single write per word, with an idle cycle between every pair of bus accesses.
module wb_copy_master #(
    parameter int LEN_W       = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_src,
    input  logic [31:0]      cmd_dst,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             abort_i,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      err_addr,
    output logic [LEN_W-1:0] xfer_cnt,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_GAP_W = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_GAP_R = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    localparam int             TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    // Command handshake: a command is taken on the rising edge where cmd_valid && cmd_ready.
    // cmd_ready is high only while idle; requests made while busy are dropped, not queued.

    logic [2:0]       state;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] len_q;
    logic             abort_pend;
    logic [TO_W-1:0]  to_cnt;

    logic [31:0] word_off;
    logic        timeout_hit;
    logic        last_word;

    assign cmd_ready   = (state == S_IDLE);
    assign word_off    = 32'(xfer_cnt) << 2;
    assign timeout_hit = (to_cnt == TO_LAST);
    assign last_word   = ((xfer_cnt + LEN_W'(1)) == len_q);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            abort_pend <= 1'b0;
            to_cnt     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_addr   <= '0;
            xfer_cnt   <= '0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_sel_o  <= 4'h0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    to_cnt <= '0;
                    if (cmd_valid) begin
                        src_q    <= cmd_src;
                        dst_q    <= cmd_dst;
                        len_q    <= cmd_len;
                        xfer_cnt <= '0;
                        err_addr <= '0;
                        busy     <= 1'b1;
                        if (cmd_len == '0) begin
                            // Empty copy: the done pulse coincides with the single busy cycle.
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_we_o  <= 1'b0;
                            wbm_sel_o <= 4'hF;
                            wbm_adr_o <= cmd_src;
                            state     <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (wbm_ack_i) begin
                        wbm_dat_o <= wbm_dat_i;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_sel_o <= 4'h0;
                        to_cnt    <= '0;
                        state     <= S_GAP_W;
                    end else if (timeout_hit) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_sel_o <= 4'h0;
                        err_addr  <= wbm_adr_o;
                        to_cnt    <= '0;
                        state     <= S_ERR;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_GAP_W: begin
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    wbm_we_o  <= 1'b1;
                    wbm_sel_o <= 4'hF;
                    wbm_adr_o <= dst_q + word_off;
                    state     <= S_WR;
                end
                S_WR: begin
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= 4'h0;
                        to_cnt    <= '0;
                        xfer_cnt  <= xfer_cnt + LEN_W'(1);
                        // An abort raised in this very cycle still stops after this word.
                        if (last_word || abort_pend || abort_i) state <= S_FIN;
                        else                                    state <= S_GAP_R;
                    end else if (timeout_hit) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= 4'h0;
                        err_addr  <= wbm_adr_o;
                        to_cnt    <= '0;
                        state     <= S_ERR;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_GAP_R: begin
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    wbm_we_o  <= 1'b0;
                    wbm_sel_o <= 4'hF;
                    wbm_adr_o <= src_q + word_off;
                    state     <= S_RD;
                end
                S_FIN: begin
                    done  <= (len_q != '0);
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (state == S_IDLE || state == S_FIN || state == S_ERR) abort_pend <= 1'b0;
            else if (abort_i)                                          abort_pend <= 1'b1;
        end
    end

endmodule
